// File: rtl/uart_line_reader_pkg.sv
// Shared ASCII constants, state encodings and helpers for the UART line reader.
// The ECHO state exists only when UART_LINE_ECHO_EN is defined.
package uart_line_reader_pkg;

    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_DEL      = 8'h7F;
    localparam logic [7:0] CH_SP       = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

`ifdef UART_LINE_ECHO_EN
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DONE    = 2'd1,
        ST_ECHO    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EK_CHAR = 2'd0,
        EK_BS   = 2'd1,
        EK_TERM = 2'd2
    } echo_kind_t;
`else
    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_DONE    = 1'b1
    } state_t;
`endif

    function automatic logic is_print(input logic [7:0] b);
        return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/uart_line_mem.sv
// Line character store: one synchronous write port, one asynchronous read port.
module uart_line_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_line_reader.sv
// Pops RX bytes, edits them into a line buffer and presents completed lines.
// Define UART_LINE_ECHO_EN to add the echo port and its ECHO state.
module uart_line_reader
    import uart_line_reader_pkg::*;
#(
    parameter int LINE_MAX = 32,
    parameter int LW       = $clog2(LINE_MAX)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          rx_empty,
    input  logic [7:0]    rx_data,
    output logic          rx_get,
    output logic          line_valid,
    output logic [LW:0]   line_len,
    output logic          line_ovf,
    input  logic [LW-1:0] rd_idx,
    output logic [7:0]    rd_char,
    input  logic          line_ack
`ifdef UART_LINE_ECHO_EN
    ,
    output logic          echo_valid,
    output logic [7:0]    echo_data,
    input  logic          echo_ready
`endif
);

    localparam logic [LW:0] LEN_MAX = (LW+1)'(LINE_MAX);

    state_t      r_state, w_next;
    logic [LW:0] r_len;
    logic        r_ovf;
    logic        w_pop, w_print, w_bs, w_term;
    logic        w_store, w_drop, w_del, w_end, w_ack;
    logic [7:0]  w_mem_rd;

    // Bytes are only consumed while collecting; everything else waits upstream.
    assign w_pop   = resetn && (r_state == ST_COLLECT) && !rx_empty;
    assign w_print = is_print(rx_data);
    assign w_bs    = (rx_data == CH_BS) || (rx_data == CH_DEL);
    assign w_term  = (rx_data == CH_CR) || (rx_data == CH_LF);
    assign w_store = w_pop && w_print && (r_len < LEN_MAX);
    assign w_drop  = w_pop && w_print && (r_len >= LEN_MAX);
    assign w_del   = w_pop && w_bs && (r_len != '0);
    assign w_end   = w_pop && w_term && ((r_len != '0) || r_ovf);
    assign w_ack   = (r_state == ST_DONE) && line_ack;

    assign rx_get     = w_pop;
    assign line_valid = (r_state == ST_DONE);
    assign line_len   = r_len;
    assign line_ovf   = r_ovf;
    assign rd_char    = ({1'b0, rd_idx} < r_len) ? w_mem_rd : 8'h00;

    uart_line_mem #(.DEPTH(LINE_MAX), .AW(LW)) u_mem (
        .clk     (clk),
        .i_we    (w_store),
        .i_waddr (r_len[LW-1:0]),
        .i_wdata (rx_data),
        .i_raddr (rd_idx),
        .o_rdata (w_mem_rd)
    );

`ifdef UART_LINE_ECHO_EN
    echo_kind_t r_kind;
    logic [7:0] r_ech;
    logic [1:0] r_step;
    logic       w_xfer, w_last;

    assign echo_valid = (r_state == ST_ECHO);
    assign w_xfer     = echo_valid && echo_ready;

    always_comb begin
        echo_data = CH_BS;
        w_last    = 1'b0;
        case (r_kind)
            EK_CHAR: begin
                echo_data = r_ech;
                w_last    = 1'b1;
            end
            EK_BS: begin
                echo_data = (r_step == 2'd1) ? CH_SP : CH_BS;
                w_last    = (r_step == 2'd2);
            end
            default: begin
                echo_data = (r_step == 2'd0) ? CH_CR : CH_LF;
                w_last    = (r_step == 2'd1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_kind <= EK_CHAR;
            r_ech  <= 8'h00;
            r_step <= 2'd0;
        end else if (w_store || w_del || w_end) begin
            r_kind <= w_store ? EK_CHAR : (w_del ? EK_BS : EK_TERM);
            r_ech  <= rx_data;
            r_step <= 2'd0;
        end else if (w_xfer) begin
            r_step <= r_step + 2'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_COLLECT;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_COLLECT: begin
`ifdef UART_LINE_ECHO_EN
                if (w_store || w_del || w_end) w_next = ST_ECHO;
`else
                if (w_end) w_next = ST_DONE;
`endif
            end
            ST_DONE: if (line_ack) w_next = ST_COLLECT;
`ifdef UART_LINE_ECHO_EN
            ST_ECHO: if (w_xfer && w_last) w_next = (r_kind == EK_TERM) ? ST_DONE : ST_COLLECT;
`endif
            default: w_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_len <= '0;
            r_ovf <= 1'b0;
        end else if (w_ack) begin
            r_len <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_store)    r_len <= r_len + 1'b1;
            else if (w_del) r_len <= r_len - 1'b1;
            if (w_drop)     r_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_line_reader.sv
// Directed self-checking bench for uart_line_reader (LINE_MAX=32).
// Define UART_LINE_ECHO_EN to also exercise the echo path.
module tb_uart_line_reader;

    localparam int LINE_MAX = 32;
    localparam int LW       = 5;

    logic          clk;
    logic          resetn;
    logic          rx_empty;
    logic [7:0]    rx_data;
    logic          rx_get;
    logic          line_valid;
    logic [LW:0]   line_len;
    logic          line_ovf;
    logic [LW-1:0] rd_idx;
    logic [7:0]    rd_char;
    logic          line_ack;
`ifdef UART_LINE_ECHO_EN
    logic          echo_valid;
    logic [7:0]    echo_data;
    logic          echo_ready;
    logic [7:0]    echo_q[$];
    logic          prev_stall;
    logic [7:0]    prev_data;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] rxq[$];

    uart_line_reader #(.LINE_MAX(LINE_MAX)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .rx_get     (rx_get),
        .line_valid (line_valid),
        .line_len   (line_len),
        .line_ovf   (line_ovf),
        .rd_idx     (rd_idx),
        .rd_char    (rd_char),
        .line_ack   (line_ack)
`ifdef UART_LINE_ECHO_EN
        ,
        .echo_valid (echo_valid),
        .echo_data  (echo_data),
        .echo_ready (echo_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: sample at negedge, let the edge happen, then update the RX buffer model.
    task automatic tick();
        logic g;
        @(negedge clk);
        g = rx_get;
`ifdef UART_LINE_ECHO_EN
        if (prev_stall) begin
            n_chk++;
            if (echo_valid !== 1'b1 || echo_data !== prev_data) begin
                n_fail++;
                $display("FAIL echo_stall: valid=%b data=%h, expected valid=1 data=%h",
                         echo_valid, echo_data, prev_data);
            end
        end
        if (echo_valid && echo_ready) echo_q.push_back(echo_data);
        prev_stall = echo_valid && !echo_ready;
        prev_data  = echo_data;
`endif
        @(posedge clk);
        #1;
        if (g && rxq.size() > 0) void'(rxq.pop_front());
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        rx_empty = 1'b0;
        rx_data  = rxq[0];
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push(s[i]);
    endtask

    task automatic wait_valid(input int max, input string nm);
        int k = 0;
        while (line_valid !== 1'b1 && k < max) begin
            tick();
            k++;
        end
        n_chk++;
        if (line_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: line_valid=%b after %0d cycles, expected 1", nm, line_valid, max);
        end
    endtask

    task automatic do_ack();
        line_ack = 1'b1;
        tick();
        line_ack = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        push("q");
        tick();
        tick();
        n_chk++;
        if (rx_get !== 1'b0) begin n_fail++; $display("FAIL reset_rx_get: got %b, expected 0", rx_get); end
        n_chk++;
        if (line_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", line_valid); end
        n_chk++;
        if (line_len !== 6'd0) begin n_fail++; $display("FAIL reset_len: got %0d, expected 0", line_len); end
        n_chk++;
        if (line_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 0", line_ovf); end
        rxq.delete();
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        resetn   = 1'b1;
        tick();
    endtask

    task automatic test_basic_line();
        logic [7:0] exp [5] = '{8'h6C, 8'h6F, 8'h6F, 8'h6B, 8'h00};
        push_str("look");
        push(8'h0D);
        wait_valid(100, "basic");
        n_chk++;
        if (line_len !== 6'd4 || line_ovf !== 1'b0) begin
            n_fail++; $display("FAIL basic_len: len=%0d ovf=%b, expected len=4 ovf=0", line_len, line_ovf);
        end
        for (int i = 0; i < 5; i++) begin
            rd_idx = LW'(i);
            #1;
            n_chk++;
            if (rd_char !== exp[i]) begin
                n_fail++; $display("FAIL basic_char%0d: got %h, expected %h", i, rd_char, exp[i]);
            end
        end
        do_ack();
        n_chk++;
        if (line_valid !== 1'b0 || line_len !== 6'd0) begin
            n_fail++; $display("FAIL basic_ack: valid=%b len=%0d, expected 0 0", line_valid, line_len);
        end
    endtask

    task automatic test_backspace();
        push(8'h08);
        push_str("ab");
        push(8'h08);
        push_str("c");
        push(8'h0A);
        wait_valid(100, "bs");
        n_chk++;
        if (line_len !== 6'd2 || line_ovf !== 1'b0) begin
            n_fail++; $display("FAIL bs_len: len=%0d ovf=%b, expected len=2 ovf=0", line_len, line_ovf);
        end
        rd_idx = 5'd0; #1;
        n_chk++;
        if (rd_char !== 8'h61) begin n_fail++; $display("FAIL bs_char0: got %h, expected 61", rd_char); end
        rd_idx = 5'd1; #1;
        n_chk++;
        if (rd_char !== 8'h63) begin n_fail++; $display("FAIL bs_char1: got %h, expected 63", rd_char); end
        rd_idx = 5'd2; #1;
        n_chk++;
        if (rd_char !== 8'h00) begin n_fail++; $display("FAIL bs_char2: got %h, expected 00", rd_char); end
        do_ack();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 40; i++) push(8'h78);
        push(8'h0D);
        wait_valid(400, "ovf");
        n_chk++;
        if (line_len !== 6'd32 || line_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_len: len=%0d ovf=%b, expected len=32 ovf=1", line_len, line_ovf);
        end
        rd_idx = 5'd31; #1;
        n_chk++;
        if (rd_char !== 8'h78) begin n_fail++; $display("FAIL ovf_char31: got %h, expected 78", rd_char); end
        do_ack();
        push_str("y");
        push(8'h0D);
        wait_valid(100, "ovf_next");
        n_chk++;
        if (line_len !== 6'd1 || line_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_next_len: len=%0d ovf=%b, expected len=1 ovf=0", line_len, line_ovf);
        end
        rd_idx = 5'd0; #1;
        n_chk++;
        if (rd_char !== 8'h79) begin n_fail++; $display("FAIL ovf_next_char: got %h, expected 79", rd_char); end
        do_ack();
    endtask

    task automatic test_all_deleted();
        // overflowed line backspaced to empty still completes with len 0
        for (int i = 0; i < 33; i++) push(8'h78);
        for (int i = 0; i < 33; i++) push(8'h7F);
        push(8'h0D);
        wait_valid(600, "alldel");
        n_chk++;
        if (line_len !== 6'd0 || line_ovf !== 1'b1) begin
            n_fail++; $display("FAIL alldel_len: len=%0d ovf=%b, expected len=0 ovf=1", line_len, line_ovf);
        end
        rd_idx = 5'd0; #1;
        n_chk++;
        if (rd_char !== 8'h00) begin n_fail++; $display("FAIL alldel_char: got %h, expected 00", rd_char); end
        do_ack();
    endtask

    task automatic test_back_to_back();
        push_str("go");
        push(8'h0D);
        push(8'h0A);
        push_str("n");
        push(8'h0D);
        wait_valid(100, "b2b");
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++;
            if (rx_get !== 1'b0 || rx_empty !== 1'b0 || line_len !== 6'd2) begin
                n_fail++;
                $display("FAIL b2b_hold%0d: rx_get=%b rx_empty=%b len=%0d, expected 0 0 2",
                         i, rx_get, rx_empty, line_len);
            end
        end
        do_ack();
        wait_valid(100, "b2b_next");
        n_chk++;
        if (line_len !== 6'd1 || line_ovf !== 1'b0) begin
            n_fail++; $display("FAIL b2b_next_len: len=%0d ovf=%b, expected len=1 ovf=0", line_len, line_ovf);
        end
        rd_idx = 5'd0; #1;
        n_chk++;
        if (rd_char !== 8'h6E) begin n_fail++; $display("FAIL b2b_next_char: got %h, expected 6E", rd_char); end
        do_ack();
    endtask

    task automatic test_ignored();
        push(8'h0D);
        push(8'h0D);
        push(8'h01);
        repeat (5) tick();
        n_chk++;
        if (line_valid !== 1'b0 || rx_empty !== 1'b1 || line_len !== 6'd0) begin
            n_fail++; $display("FAIL blank: valid=%b empty=%b len=%0d, expected 0 1 0", line_valid, rx_empty, line_len);
        end
        // ack while collecting must not clear the partial line
        line_ack = 1'b1;
        push_str("ab");
        repeat (20) tick();
        line_ack = 1'b0;
        push(8'h0D);
        wait_valid(100, "early_ack");
        n_chk++;
        if (line_len !== 6'd2) begin n_fail++; $display("FAIL early_ack_len: got %0d, expected 2", line_len); end
        do_ack();
    endtask

    task automatic test_reset_mid();
        push_str("ab");
        repeat (12) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_chk++;
        if (line_valid !== 1'b0 || line_len !== 6'd0) begin
            n_fail++; $display("FAIL rstmid: valid=%b len=%0d, expected 0 0", line_valid, line_len);
        end
        push_str("x");
        push(8'h0D);
        wait_valid(100, "rstmid_next");
        n_chk++;
        if (line_len !== 6'd1) begin n_fail++; $display("FAIL rstmid_len: got %0d, expected 1", line_len); end
        rd_idx = 5'd0; #1;
        n_chk++;
        if (rd_char !== 8'h78) begin n_fail++; $display("FAIL rstmid_char: got %h, expected 78", rd_char); end
        do_ack();
    endtask

`ifdef UART_LINE_ECHO_EN
    task automatic test_echo();
        logic [7:0] exp [7] = '{8'h61, 8'h08, 8'h20, 8'h08, 8'h62, 8'h0D, 8'h0A};
        echo_q.delete();
        echo_ready = 1'b0;
        push_str("a");
        push(8'h08);
        push_str("b");
        push(8'h0D);
        for (int k = 0; k < 7; k++) begin
            repeat (5) tick();
            if (k == 6) begin
                n_chk++;
                if (line_valid !== 1'b0) begin n_fail++; $display("FAIL echo_early_valid: got %b, expected 0", line_valid); end
            end
            echo_ready = 1'b1;
            tick();
            echo_ready = 1'b0;
        end
        n_chk++;
        if (echo_q.size() != 7) begin
            n_fail++; $display("FAIL echo_count: got %0d, expected 7", echo_q.size());
        end
        for (int i = 0; i < 7; i++) begin
            if (i < echo_q.size()) begin
                n_chk++;
                if (echo_q[i] !== exp[i]) begin
                    n_fail++; $display("FAIL echo_byte%0d: got %h, expected %h", i, echo_q[i], exp[i]);
                end
            end
        end
        n_chk++;
        if (line_valid !== 1'b1 || line_len !== 6'd1 || line_ovf !== 1'b0) begin
            n_fail++; $display("FAIL echo_line: valid=%b len=%0d ovf=%b, expected 1 1 0", line_valid, line_len, line_ovf);
        end
        echo_ready = 1'b1;
        do_ack();
    endtask
`endif

    initial begin
        resetn   = 1'b0;
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        rd_idx   = '0;
        line_ack = 1'b0;
`ifdef UART_LINE_ECHO_EN
        echo_ready = 1'b1;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
`endif
        test_reset();
        test_basic_line();
        test_backspace();
        test_overflow();
        test_all_deleted();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
`ifdef UART_LINE_ECHO_EN
        test_echo();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
